// File: rtl/ps2_mouse_packet_rx.sv
// rtl/ps2_mouse_packet_rx.sv - PS/2 mouse receiver: oversampled frame decode and packet assembly
//
// Ports:
//   clock_100Mhz           system clock; every register lives in this domain
//   reset                  synchronous, active-high
//   Mouse_Clk, Mouse_Data  asynchronous PS/2 lines, synchronised and filtered here
//   packet_valid           one-cycle strobe; the field outputs update in the same cycle and then hold
//   btn_left/right/middle  button states from byte 0
//   dx, dy                 9-bit signed movement, {sign, byte}
//   dz                     4-bit signed wheel movement (0 in 3-byte mode)
//   x_ovf, y_ovf           overflow flags from byte 0
//   frame_err              one-cycle strobe on a rejected byte, a rejected packet or a timeout
//   busy                   frame or packet in progress
module ps2_mouse_packet_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int PACKET_BYTES   = 3
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic       Mouse_Clk,
  input  logic       Mouse_Data,
  output logic       packet_valid,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_middle,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic [3:0] dz,
  output logic       x_ovf,
  output logic       y_ovf,
  output logic       frame_err,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    LAST_IDX  = 2'(PACKET_BYTES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic          clk_f_q, clk_f_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [1:0]    idx_q, idx_d;
  // Byte 0 minus its always-one sync bit: {Yovf, Xovf, Ysign, Xsign, M, R, L}
  logic [6:0]    b0_q, b0_d;
  logic [7:0]    b1_q, b1_d, b2_q, b2_d;
  logic          pv_q, pv_d, fe_q, fe_d;
  logic          bl_q, bl_d, br_q, br_d, bm_q, bm_d, xo_q, xo_d, yo_q, yo_d;
  logic [8:0]    dx_q, dx_d, dy_q, dy_d;
  logic [3:0]    dz_q, dz_d;
  logic          sample_evt, busy_int, timeout, byte_ok;

  assign busy_int = (state_q != IDLE) || (idx_q != 2'd0);

  // The filtered clock flips on the FILTER_LEN-th consecutive sample that
  // disagrees with it; a falling flip is the sample event.
  assign sample_evt = (clk_sync_q != clk_f_q) && (filt_cnt_q == FILT_LAST) && !clk_sync_q;

  // A sample event landing on the terminal count suppresses the timeout.
  assign timeout = busy_int && !sample_evt && (to_cnt_q == TO_LAST);

  // 8 data bits plus parity must hold an odd number of ones, stop bit must be 1.
  assign byte_ok = (^{shift_q, par_q}) && dat_sync_q;

  always_comb begin
    clk_f_d    = clk_f_q;
    filt_cnt_d = '0;
    if (clk_sync_q != clk_f_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        clk_f_d = clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    idx_d    = idx_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    b2_d     = b2_q;
    pv_d     = 1'b0;
    fe_d     = 1'b0;
    bl_d     = bl_q;
    br_d     = br_q;
    bm_d     = bm_q;
    xo_d     = xo_q;
    yo_d     = yo_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    dz_d     = dz_q;
    to_cnt_d = (sample_evt || !busy_int || timeout) ? '0 : to_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (sample_evt && !dat_sync_q) begin
          state_d  = DATA;
          bitcnt_d = 3'd0;
        end
      end
      DATA: begin
        if (sample_evt) begin
          shift_d  = {dat_sync_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (sample_evt) begin
          par_d   = dat_sync_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample_evt) begin
          state_d = IDLE;
          if (!byte_ok) begin
            fe_d  = 1'b1;
            idx_d = 2'd0;
          end else if (idx_q == 2'd0) begin
            // Bit 3 of byte 0 is the resync marker; a byte without it is dropped.
            if (shift_q[3]) begin
              b0_d  = {shift_q[7:4], shift_q[2:0]};
              idx_d = 2'd1;
            end else begin
              fe_d = 1'b1;
            end
          end else if (idx_q == LAST_IDX) begin
            pv_d  = 1'b1;
            idx_d = 2'd0;
            bl_d  = b0_q[0];
            br_d  = b0_q[1];
            bm_d  = b0_q[2];
            xo_d  = b0_q[5];
            yo_d  = b0_q[6];
            dx_d  = {b0_q[3], b1_q};
            dy_d  = {b0_q[4], (PACKET_BYTES == 4) ? b2_q : shift_q};
            dz_d  = (PACKET_BYTES == 4) ? shift_q[3:0] : 4'd0;
          end else begin
            if (idx_q == 2'd1) b1_d = shift_q;
            else               b2_d = shift_q;
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      fe_d    = 1'b1;
    end
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      state_q    <= IDLE;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      clk_f_q    <= 1'b1;
      filt_cnt_q <= '0;
      to_cnt_q   <= '0;
      bitcnt_q   <= 3'd0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      idx_q      <= 2'd0;
      b0_q       <= 7'd0;
      b1_q       <= 8'd0;
      b2_q       <= 8'd0;
      pv_q       <= 1'b0;
      fe_q       <= 1'b0;
      bl_q       <= 1'b0;
      br_q       <= 1'b0;
      bm_q       <= 1'b0;
      xo_q       <= 1'b0;
      yo_q       <= 1'b0;
      dx_q       <= 9'd0;
      dy_q       <= 9'd0;
      dz_q       <= 4'd0;
    end else begin
      state_q    <= state_d;
      clk_meta_q <= Mouse_Clk;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= Mouse_Data;
      dat_sync_q <= dat_meta_q;
      clk_f_q    <= clk_f_d;
      filt_cnt_q <= filt_cnt_d;
      to_cnt_q   <= to_cnt_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      idx_q      <= idx_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      pv_q       <= pv_d;
      fe_q       <= fe_d;
      bl_q       <= bl_d;
      br_q       <= br_d;
      bm_q       <= bm_d;
      xo_q       <= xo_d;
      yo_q       <= yo_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      dz_q       <= dz_d;
    end
  end

  assign packet_valid = pv_q;
  assign frame_err    = fe_q;
  assign btn_left     = bl_q;
  assign btn_right    = br_q;
  assign btn_middle   = bm_q;
  assign x_ovf        = xo_q;
  assign y_ovf        = yo_q;
  assign dx           = dx_q;
  assign dy           = dy_q;
  assign dz           = dz_q;
  assign busy         = busy_int;

endmodule

// File: doc/ps2_mouse_packet_rx.md
# ps2_mouse_packet_rx

Parametrised PS/2 mouse receiver that runs entirely in the `clock_100Mhz` domain and oversamples the asynchronous `Mouse_Clk` and `Mouse_Data` lines. It glitch-filters the PS/2 clock and decodes 11-bit frames (start bit, 8 data bits, odd parity, stop bit). It assembles standard 3-byte packets, or 4-byte wheel packets, into decoded button, movement and wheel fields. Each packet is delivered with a one-cycle valid strobe. The block sits between the PS/2 pins and the counter/display logic, and replaces direct clocking of logic from `Mouse_Clk`.

## Interface
Parameters:
- FILTER_LEN, 8: number of consecutive identical synchronised `Mouse_Clk` samples required before the filtered clock changes state.
- TIMEOUT_CYCLES, 200000: idle limit in clock cycles (2 ms at 100 MHz) between sample events while a frame or packet is in progress.
- PACKET_BYTES, 3: bytes per packet; legal values are 3 and 4.

Ports:
- clock_100Mhz  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- Mouse_Clk  in  1  PS/2 clock, asynchronous.
- Mouse_Data  in  1  PS/2 data, asynchronous.
- packet_valid  out  1  one-cycle strobe; all packet fields are valid in this cycle and hold their values afterwards.
- btn_left, btn_right, btn_middle  out  1 each  button states.
- dx, dy  out  9 each  signed two's-complement movement.
- dz  out  4  signed wheel movement; tied to 0 when PACKET_BYTES=3.
- x_ovf, y_ovf  out  1 each  overflow flags from byte 0.
- frame_err  out  1  one-cycle strobe on any rejected byte or packet.
- busy  out  1  high while a frame or packet is in progress.

## Operation
- **Synchronisation:** both input lines pass through 2-flop synchronisers.
- **Clock filter:** `clk_f` (reset value 1) takes the synchronised `Mouse_Clk` value only after FILTER_LEN consecutive equal samples.
- **Sample event:** a sample event occurs in the cycle where `clk_f` falls 1→0. In that cycle the synchronised data bit is captured.
- **Frame FSM (reset state IDLE):**
  - IDLE: on a sample event with data=0, go to DATA and set bitcnt=0. A sample event with data=1 is ignored and the FSM stays in IDLE.
  - DATA: shift data in LSB first; after the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: on the sample event, the byte is accepted only if the 9 bits (8 data + parity) contain an odd number of ones and the stop bit is 1. Otherwise pulse `frame_err` and clear the byte index to 0. The FSM returns to IDLE in both cases.
- **Packet assembly (byte index 0..PACKET_BYTES-1):**
  - Byte 0 must have bit3=1. If not, discard it, pulse `frame_err`, and keep the index at 0.
  - Byte 0 field map: [0] L, [1] R, [2] M, [4] X sign, [5] Y sign, [6] X ovf, [7] Y ovf.
  - Byte 1 is X, byte 2 is Y, byte 3 (4-byte mode only) is Z; dz = byte3[3:0].
  - When the final byte is accepted, register all fields and pulse `packet_valid`. dx = {Xsign, byte1}; dy = {Ysign, byte2}.
- **Timeout:** a counter clears on every sample event and counts while `busy`=1. On reaching TIMEOUT_CYCLES: pulse `frame_err`, force the FSM to IDLE, clear the byte index, and clear the counter.
- **busy** = (FSM ≠ IDLE) or (byte index ≠ 0).
- **Reset:** all outputs go to 0; `clk_f`=1; FSM=IDLE; counters and byte index = 0. A reset mid-frame or mid-packet discards everything collected so far, and no `packet_valid` is produced for it.

## Timing
- A physical falling edge on `Mouse_Clk` becomes a sample event 2 + FILTER_LEN cycles later (±1 cycle for synchroniser phase).
- `packet_valid` and `frame_err` go high in the cycle after the deciding sample event, for exactly one cycle. The two never assert in the same cycle.
- Output fields update in the same cycle as `packet_valid` and are stable until the next `packet_valid` or reset.
- If a sample event and a timeout fall in the same cycle, the sample event wins: the counter clears and there is no timeout.
- After a timeout, a new start bit is accepted on the very next sample event.
- Bit 3 is checked only on byte 0; bytes 1..N-1 are not checked for it.

## Test plan
- **Normal packet:** reset, then send a 3-byte packet 0x29, 0x05, 0xFB at a 12.5 kHz PS/2 clock → exactly one `packet_valid`; btn_left=1, btn_right=0, btn_middle=0; dx=9'h005; dy=9'h1FB; `frame_err` never asserts.
- **Parity error:** corrupt the parity bit of byte 1, then send a valid packet 0x0A, 0x10, 0x00 → one `frame_err`, no `packet_valid` for the bad packet. The next packet gives btn_right=1, dx=9'h010, dy=0.
- **Bad sync bit:** send byte 0x01 (bit3=0), then a valid packet → `frame_err` once, the 0x01 byte is discarded, and the following packet decodes correctly.
- **Timeout:** send 2 bytes, then hold `Mouse_Clk` high for TIMEOUT_CYCLES+10 cycles → `frame_err` pulses once and `busy` falls to 0. A following full packet is accepted.
- **Glitch and reset:** a `Mouse_Clk` low glitch of FILTER_LEN-2 cycles while idle → no sample event and `busy` stays 0. Assert `reset` mid-byte → outputs return to 0, `busy`=0, and no strobe is produced.
- **4-byte mode:** with PACKET_BYTES=4, send 0x08, 0x00, 0x00, 0x0F → one `packet_valid` after the 4th byte with dz=4'hF (−1).
